// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IRD,
    ST_DRD,
    ST_DWR,
    ST_DRESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int unsigned WORD_STRIDE = 4;

  function automatic int unsigned burst_len(input int unsigned offset_width);
    return 32'd1 << offset_width;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the icache, dcache and memory-side signals of the arbiter.
interface mem_arbiter_if;
  logic        i_rvalid;
  logic [31:0] i_raddr;
  logic        i_rready;
  logic [31:0] i_rdata;
  logic        i_rlast;

  logic        d_rvalid;
  logic [31:0] d_raddr;
  logic        d_rready;
  logic [31:0] d_rdata;
  logic        d_rlast;

  logic        d_wvalid;
  logic [31:0] d_waddr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wready;
  logic        d_bvalid;
  logic        d_bready;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  i_rvalid, i_raddr, d_rvalid, d_raddr,
    input  d_wvalid, d_waddr, d_wdata, d_wstrb, d_bready,
    input  m_ack, m_rdata,
    output i_rready, i_rdata, i_rlast, d_rready, d_rdata, d_rlast,
    output d_wready, d_bvalid,
    output m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_rvalid, i_raddr, d_rvalid, d_raddr,
    output d_wvalid, d_waddr, d_wdata, d_wstrb, d_bready,
    output m_ack, m_rdata,
    input  i_rready, i_rdata, i_rlast, d_rready, d_rdata, d_rlast,
    input  d_wready, d_bvalid,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for one burst: clears between bursts, advances per acknowledged beat.
module burst_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_last
);
  localparam int unsigned LAST_BEAT = burst_len(WIDTH) - 1;

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == WIDTH'(LAST_BEAT));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory beat port between icache line reads and dcache reads/writes;
// a granted burst runs to completion before the next grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_OFFSET_WIDTH = 2
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  arb_state_t r_state, w_state_next;
  grant_t     r_last_grant, w_last_grant_next;
  logic [31:0] r_base, w_base_next;

  logic [WORD_OFFSET_WIDTH-1:0] w_cnt;
  logic        w_clr, w_inc, w_last;
  logic [31:0] w_addr;

  logic        w_i_rready, w_i_rlast, w_d_rready, w_d_rlast;
  logic [31:0] w_i_rdata, w_d_rdata;
  logic        w_d_wready, w_d_bvalid;
  logic        w_m_req, w_m_we;
  logic [31:0] w_m_addr, w_m_wdata;
  logic [3:0]  w_m_wstrb;

  burst_counter #(.WIDTH(WORD_OFFSET_WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  assign w_addr = r_base + (32'(w_cnt) * WORD_STRIDE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_I;
      r_base       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_base       <= w_base_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_base_next       = r_base;
    w_clr             = 1'b0;
    w_inc             = 1'b0;
    w_i_rready        = 1'b0;
    w_i_rdata         = '0;
    w_i_rlast         = 1'b0;
    w_d_rready        = 1'b0;
    w_d_rdata         = '0;
    w_d_rlast         = 1'b0;
    w_d_wready        = 1'b0;
    w_d_bvalid        = 1'b0;
    w_m_req           = 1'b0;
    w_m_we            = 1'b0;
    w_m_addr          = '0;
    w_m_wdata         = '0;
    w_m_wstrb         = '0;

    case (r_state)
      ST_IDLE: begin
        // Counter is held clear while idle so every burst starts at beat 0.
        w_clr = 1'b1;
        if (bus.d_wvalid) begin
          w_state_next = ST_DWR;
          w_base_next  = bus.d_waddr;
        end else if (bus.i_rvalid && bus.d_rvalid) begin
          if (r_last_grant == GRANT_I) begin
            w_state_next = ST_DRD;
            w_base_next  = bus.d_raddr;
          end else begin
            w_state_next = ST_IRD;
            w_base_next  = bus.i_raddr;
          end
        end else if (bus.i_rvalid) begin
          w_state_next = ST_IRD;
          w_base_next  = bus.i_raddr;
        end else if (bus.d_rvalid) begin
          w_state_next = ST_DRD;
          w_base_next  = bus.d_raddr;
        end
      end

      ST_IRD, ST_DRD: begin
        w_m_req  = 1'b1;
        w_m_addr = w_addr;
        w_inc    = bus.m_ack;
        if (r_state == ST_IRD) begin
          w_i_rready = bus.m_ack;
          w_i_rdata  = bus.m_ack ? bus.m_rdata : '0;
          w_i_rlast  = bus.m_ack && w_last;
        end else begin
          w_d_rready = bus.m_ack;
          w_d_rdata  = bus.m_ack ? bus.m_rdata : '0;
          w_d_rlast  = bus.m_ack && w_last;
        end
        if (bus.m_ack && w_last) begin
          w_state_next      = ST_IDLE;
          w_last_grant_next = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end
      end

      ST_DWR: begin
        w_m_req    = bus.d_wvalid;
        w_m_we     = 1'b1;
        w_m_addr   = w_addr;
        w_m_wdata  = bus.d_wdata;
        w_m_wstrb  = bus.d_wstrb;
        w_d_wready = bus.m_ack;
        w_inc      = bus.m_ack;
        if (bus.m_ack && w_last) begin
          w_state_next = ST_DRESP;
        end
      end

      ST_DRESP: begin
        w_d_bvalid = 1'b1;
        if (bus.d_bready) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.i_rready = w_i_rready;
  assign bus.i_rdata  = w_i_rdata;
  assign bus.i_rlast  = w_i_rlast;
  assign bus.d_rready = w_d_rready;
  assign bus.d_rdata  = w_d_rdata;
  assign bus.d_rlast  = w_d_rlast;
  assign bus.d_wready = w_d_wready;
  assign bus.d_bvalid = w_d_bvalid;
  assign bus.m_req    = w_m_req;
  assign bus.m_we     = w_m_we;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.m_wstrb  = w_m_wstrb;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario table plus a mid-burst reset sequence.
module tb_mem_arbiter;
  typedef enum logic [1:0] {K_NONE, K_I, K_D, K_W} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          last;
  } beat_t;

  typedef struct {
    bit          irv;
    bit          drv;
    bit          dwv;
    bit          early;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wa;
    int          gap;
    int          bdelay;
    kind_t       o0;
    kind_t       o1;
    kind_t       o2;
  } vec_t;

  localparam int BL = 4;
  localparam int NVEC = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.WORD_OFFSET_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    total = 0;
  int    bad = 0;
  beat_t sb[$];
  int    gap_cnt, cur_gap, bdelay, bcnt, beats_done, wbeat;
  bit    bresp_pending, prev_last, early;
  vec_t  vecs[NVEC];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] wdata_fn(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  function automatic logic [3:0] strb_fn(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return 4'hF ^ (one << k);
  endfunction

  function automatic bit all_zero();
    return !(bus.i_rready || bus.i_rlast || bus.d_rready || bus.d_rlast ||
             bus.d_wready || bus.d_bvalid || bus.m_req || bus.m_we) &&
           bus.i_rdata == 32'h0 && bus.d_rdata == 32'h0 && bus.m_addr == 32'h0 &&
           bus.m_wdata == 32'h0 && bus.m_wstrb == 4'h0;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input kind_t kind, input logic [31:0] base);
    beat_t e;
    for (int k = 0; k < BL; k++) begin
      e.kind = kind;
      e.addr = base + 32'(4 * k);
      e.data = wdata_fn(k);
      e.strb = strb_fn(k);
      e.last = (k == BL - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.i_rvalid = 1'b0; bus.i_raddr = '0;
    bus.d_rvalid = 1'b0; bus.d_raddr = '0;
    bus.d_wvalid = 1'b0; bus.d_waddr = '0;
    bus.d_wdata  = '0;   bus.d_wstrb = '0;
    bus.d_bready = 1'b0;
    bus.m_ack    = 1'b0; bus.m_rdata = '0;
  endtask

  // One clock of memory model, scoreboard pop and requester reaction.
  task automatic step();
    beat_t e;
    bit    ok, v, own_rr, own_rl, oth_rr;
    logic [31:0] own_rd;
    @(negedge clk);
    bus.d_bready = 1'b0;
    bus.m_ack    = 1'b0;
    bus.m_rdata  = '0;
    if (bus.m_req) begin
      if (gap_cnt >= cur_gap) begin
        bus.m_ack = 1'b1;
        gap_cnt   = 0;
        if (!bus.m_we) bus.m_rdata = mem_fn(bus.m_addr);
      end else begin
        gap_cnt++;
      end
    end else begin
      gap_cnt = 0;
    end
    #1;
    if (prev_last) check(!bus.m_req, "idle_gap", 32'(bus.m_req), 32'h0);
    prev_last = 1'b0;
    if (bus.m_req) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_req", bus.m_addr, 32'h0);
      end else if (!bus.m_ack) begin
        check(bus.m_addr == sb[0].addr, "addr_hold", bus.m_addr, sb[0].addr);
      end else begin
        e = sb.pop_front();
        beats_done++;
        if (e.kind == K_W) begin
          ok = bus.m_we && bus.d_wready && !bus.i_rready && !bus.d_rready &&
               bus.m_addr == e.addr && bus.m_wdata == e.data && bus.m_wstrb == e.strb;
          check(ok, "wr_beat", bus.m_addr ^ bus.m_wdata, e.addr ^ e.data);
          wbeat++;
          bus.d_wdata = wdata_fn(wbeat);
          bus.d_wstrb = strb_fn(wbeat);
          if (e.last) begin
            bus.d_wvalid = 1'b0;
            prev_last    = 1'b1;
          end
        end else begin
          v      = (e.kind == K_I) ? bus.i_rvalid : bus.d_rvalid;
          own_rr = (e.kind == K_I) ? bus.i_rready : bus.d_rready;
          own_rd = (e.kind == K_I) ? bus.i_rdata  : bus.d_rdata;
          own_rl = (e.kind == K_I) ? bus.i_rlast  : bus.d_rlast;
          oth_rr = (e.kind == K_I) ? bus.d_rready : bus.i_rready;
          ok = !bus.m_we && bus.m_addr == e.addr && !oth_rr && !bus.d_wready &&
               (!v || (own_rr && own_rd == mem_fn(e.addr) && own_rl == e.last));
          check(ok, (e.kind == K_I) ? "i_beat" : "d_beat", bus.m_addr, e.addr);
          if (e.last || early) begin
            if (e.kind == K_I) bus.i_rvalid = 1'b0;
            else bus.d_rvalid = 1'b0;
          end
          if (e.last) prev_last = 1'b1;
        end
      end
    end
    if (bus.d_bvalid) begin
      bcnt++;
      check(!bus.m_req && !bus.i_rready && !bus.d_rready, "resp_no_grant", 32'(bus.m_req), 32'h0);
      if (bcnt > bdelay) begin
        bus.d_bready  = 1'b1;
        bresp_pending = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check(all_zero(), "reset_outputs", 32'(bus.m_req), 32'h0);
    rst = 1'b0;
    sb.delete();
    gap_cnt = 0; bcnt = 0; beats_done = 0; wbeat = 0;
    prev_last = 1'b0; bresp_pending = 1'b0; early = 1'b0;
  endtask

  task automatic push_kind(input kind_t k, input vec_t r);
    case (k)
      K_I:     push_burst(K_I, r.ia);
      K_D:     push_burst(K_D, r.da);
      K_W:     push_burst(K_W, r.wa);
      default: ;
    endcase
  endtask

  task automatic run_vec(input int idx, input vec_t r);
    int cyc;
    do_reset();
    cur_gap = r.gap;
    bdelay  = r.bdelay;
    early   = r.early;
    push_kind(r.o0, r);
    push_kind(r.o1, r);
    push_kind(r.o2, r);
    bus.i_raddr  = r.ia; bus.d_raddr = r.da; bus.d_waddr = r.wa;
    bus.d_wdata  = wdata_fn(0);
    bus.d_wstrb  = strb_fn(0);
    bus.i_rvalid = r.irv;
    bus.d_rvalid = r.drv;
    bus.d_wvalid = r.dwv;
    bresp_pending = r.dwv;
    cyc = 0;
    while (cyc < 300 && !(sb.size() == 0 && !bus.i_rvalid && !bus.d_rvalid &&
                          !bus.d_wvalid && !bresp_pending)) begin
      step();
      cyc++;
    end
    check(cyc < 300, "timeout", 32'(cyc), 32'd300);
    check(sb.size() == 0, "beats_left", 32'(sb.size()), 32'h0);
    if (r.dwv) check(bcnt == bdelay + 1, "bvalid_len", 32'(bcnt), 32'(bdelay + 1));
    @(negedge clk);
    bus.m_ack = 1'b0;
    bus.d_bready = 1'b0;
    #1;
    check(all_zero(), "idle_after", 32'(bus.m_req), 32'h0);
    $display("vec %0d: beats=%0d bvalid_cycles=%0d cycles=%0d", idx, beats_done, bcnt, cyc);
  endtask

  initial begin
    int cyc;
    drive_idle_inputs();

    //          irv drv dwv early  ia            da            wa           gap bdly  order
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0, 0, K_I, K_NONE, K_NONE};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0200, 32'h0, 0, 0, K_D, K_I, K_NONE};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'h0000_0400, 0, 3, K_W, K_D, K_I};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0500, 32'h0, 2, 0, K_D, K_NONE, K_NONE};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 1, 0, K_I, K_NONE, K_NONE};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_0800, 1, 0, K_W, K_NONE, K_NONE};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0, 32'h0, 0, 0, K_I, K_NONE, K_NONE};

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a slow burst: abandon it and come back idle.
    do_reset();
    cur_gap = 2;
    push_burst(K_I, 32'h0000_0600);
    bus.i_raddr  = 32'h0000_0600;
    bus.i_rvalid = 1'b1;
    cyc = 0;
    while (beats_done < 2 && cyc < 100) begin
      step();
      cyc++;
    end
    check(beats_done == 2, "rst_seq_beats", 32'(beats_done), 32'd2);
    rst = 1'b1;
    bus.i_rvalid = 1'b0;
    @(negedge clk);
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    #1;
    check(all_zero(), "after_rst", 32'(bus.m_req), 32'h0);
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check(!bus.m_req, "rst_stays_idle", 32'(bus.m_req), 32'h0);
    end
    $display("rst_seq: beats_before_rst=%0d", beats_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 SHALL have parameter WORD_OFFSET_WIDTH, default 2; burst length BURST_LEN = 2**WORD_OFFSET_WIDTH words of 32 bits.
REQ-002 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_rvalid  input  1  icache line-read request, held until i_rlast beat.
REQ-005 SHALL have i_raddr  input  32  icache burst start address, word-aligned.
REQ-006 SHALL have i_rready  output  1  icache read beat valid.
REQ-007 SHALL have i_rdata  output  32  icache read beat data.
REQ-008 SHALL have i_rlast  output  1  final icache beat.
REQ-009 SHALL have d_rvalid  input  1  dcache line-read request, held until d_rlast beat.
REQ-010 SHALL have d_raddr  input  32  dcache read start address, word-aligned.
REQ-011 SHALL have d_rready  output  1  dcache read beat valid.
REQ-012 SHALL have d_rdata  output  32  dcache read beat data.
REQ-013 SHALL have d_rlast  output  1  final dcache read beat.
REQ-014 SHALL have d_wvalid  input  1  dcache write beat valid; held through burst.
REQ-015 SHALL have d_waddr  input  32  dcache write start address, word-aligned.
REQ-016 SHALL have d_wdata  input  32  current write beat data.
REQ-017 SHALL have d_wstrb  input  4  current write beat byte strobes.
REQ-018 SHALL have d_wready  output  1  write beat accepted.
REQ-019 SHALL have d_bvalid  output  1  write burst complete response.
REQ-020 SHALL have d_bready  input  1  dcache accepts response.
REQ-021 SHALL have m_req  output  1  memory beat request.
REQ-022 SHALL have m_we  output  1  1 = write beat, 0 = read beat.
REQ-023 SHALL have m_addr  output  32  beat address.
REQ-024 SHALL have m_wdata  output  32  write beat data.
REQ-025 SHALL have m_wstrb  output  4  write beat strobes.
REQ-026 SHALL have m_ack  input  1  memory completes current beat this cycle.
REQ-027 SHALL have m_rdata  input  32  read data, valid when m_ack and !m_we.
Function
REQ-028 SHALL implement FSM IDLE, IRD, DRD, DWR, DRESP; exactly one owner of memory port per burst, no preemption.
REQ-029 SHALL, in IDLE, select: d_wvalid -> DWR; else both reads pending -> requester opposite to last_grant; else sole pending read; none -> stay IDLE.
REQ-030 SHALL latch start address into base and clear beat counter cnt on IDLE exit; first m_req the cycle after grant.
REQ-031 SHALL drive m_addr = base + 4*cnt (32-bit wrap, no line wrap); cnt increments only on m_ack.
REQ-032 SHALL, in IRD/DRD, hold m_req=1, m_we=0; on m_ack assert owner's rready=1, rdata=m_rdata combinationally, rlast=1 when cnt==BURST_LEN-1.
REQ-033 SHALL, in DWR, drive m_req=d_wvalid, m_we=1, m_wdata=d_wdata, m_wstrb=d_wstrb, d_wready=m_ack.
REQ-034 SHALL end bursts by own counter: last read beat -> IDLE, toggling last_grant; last write beat -> DRESP; last_grant unchanged by writes.
REQ-035 SHALL, in DRESP, hold d_bvalid=1 until d_bready, then IDLE; no new grant while DRESP.
REQ-036 SHALL hold m_addr, cnt, state while m_ack=0 (unbounded wait).
REQ-037 SHALL complete a granted read burst even if requester deasserts valid mid-burst, discarding data (protocol violation tolerated).
REQ-038 SHALL drive all non-owner outputs 0; always insert one IDLE cycle between bursts.
Reset
REQ-039 SHALL on rst force state IDLE, cnt=0, base=0, last_grant=I, and all outputs 0 from next cycle, abandoning any burst mid-operation.
Structure
REQ-040 SHALL take state enum, BURST_LEN derivation and word stride constant (4) from shared package mem_arb_pkg.
REQ-041 SHALL instantiate one sub-module burst_counter (cnt, increment on m_ack, last flag, clear).
Verification
REQ-042 SHALL cover i_rvalid=1, i_raddr=0x100, m_ack every cycle -> m_addr 0x100,0x104,0x108,0x10C; i_rlast on 4th beat; IDLE next.
REQ-043 SHALL cover i_rvalid and d_rvalid rising together after reset -> DRD burst first (0x200..0x20C), then IRD burst.
REQ-044 SHALL cover d_wvalid, d_rvalid, i_rvalid simultaneous -> DWR first with 4 d_wready pulses, DRESP, then round-robin reads.
REQ-045 SHALL cover DRESP with d_bready low 3 cycles -> d_bvalid held 4 cycles, m_req 0, pending i_rvalid not granted.
REQ-046 SHALL cover m_ack every third cycle and rst asserted after beat 2 -> m_addr stable across gaps; all outputs 0 and IDLE the cycle after rst.
